// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file's single write port
// between the ALU (port 0) and load (port 1) requesters. Optional macro: RFWB_R0_DISCARD_EN.
module regfile_wb_arbiter #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_SIZE = $clog2(DEPTH),
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [WIDTH-1:0]     req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [WIDTH-1:0]     req1_data,
  output logic                 req1_ready,
  output logic                 rf_we,
  output logic [ADDR_SIZE-1:0] rf_addr,
  output logic [WIDTH-1:0]     rf_wdata,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 r_last;
  logic                 r_we;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_xfer;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [WIDTH-1:0]     w_data;
  logic                 w_we_next;
  logic                 w_both;

  // Grant selection: a lone requester wins; on a tie the port that did not win last time wins.
  always_comb begin
    w_grant0  = 1'b0;
    w_grant1  = 1'b0;
    w_addr    = req0_addr;
    w_data    = req0_data;
    w_we_next = 1'b0;
    w_both    = req0_valid & req1_valid;
    if (rst) begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end else begin
      w_grant0 = req0_valid & (~req1_valid | r_last);
      w_grant1 = req1_valid & (~req0_valid | ~r_last);
    end
    w_xfer = w_grant0 | w_grant1;
    if (w_grant1) begin
      w_addr = req1_addr;
      w_data = req1_data;
    end else begin
      w_addr = req0_addr;
      w_data = req0_data;
    end
`ifdef RFWB_R0_DISCARD_EN
    // r0 is hardwired to zero: complete the handshake but never enable the write.
    w_we_next = w_xfer & (w_addr != {ADDR_SIZE{1'b0}});
`else
    w_we_next = w_xfer;
`endif
  end

  // Round-robin pointer: remembers the most recently granted port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_grant1;
    end else begin
      r_last <= r_last;
    end
  end

  // Write-port register: address and data hold when no write is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= {ADDR_SIZE{1'b0}};
      r_wdata <= {WIDTH{1'b0}};
    end else if (w_xfer) begin
      r_we    <= w_we_next;
      r_addr  <= w_addr;
      r_wdata <= w_data;
    end else begin
      r_we    <= 1'b0;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

  // Contention counter: saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_both && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;
  assign rf_we        = r_we;
  assign rf_addr      = r_addr;
  assign rf_wdata     = r_wdata;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; honours RFWB_R0_DISCARD_EN like the design.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic [7:0]  conflict_cnt;
  logic [15:0] model_rf [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
  );

  // Register file stand-in that captures the arbiter's writes.
  always @(posedge clk) begin
    if (rf_we) model_rf[rf_addr] <= rf_wdata;
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_d;
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 16'h0000;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 16'h0000;
    for (int i = 0; i < 32; i++) model_rf[i] = 16'h0000;
    @(negedge clk);
    rst = 1'b0;

    // Single writer
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 16'h1234;
    #1;
    expect_eq("single_ready0", {31'd0, req0_ready}, 32'd1);
    expect_eq("single_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    expect_eq("single_we", {31'd0, rf_we}, 32'd1);
    expect_eq("single_addr", {27'd0, rf_addr}, 32'd5);
    expect_eq("single_data", {16'd0, rf_wdata}, 32'h1234);
    req0_valid = 1'b0;
    tick();
    expect_eq("single_we_drop", {31'd0, rf_we}, 32'd0);
    expect_eq("single_addr_hold", {27'd0, rf_addr}, 32'd5);
    expect_eq("single_data_hold", {16'd0, rf_wdata}, 32'h1234);

    // Mid-cycle reset with a pending write in the output register
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 16'hBEEF;
    tick();
    expect_eq("pre_rst_we", {31'd0, rf_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    expect_eq("rst_we", {31'd0, rf_we}, 32'd0);
    expect_eq("rst_addr", {27'd0, rf_addr}, 32'd0);
    expect_eq("rst_data", {16'd0, rf_wdata}, 32'd0);
    expect_eq("rst_cnt", {24'd0, conflict_cnt}, 32'd0);
    expect_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
    expect_eq("rst_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;

    // Round-robin from reset: grants 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 16'h1000;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 16'h2000;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_eq("rr_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      expect_eq("rr_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      case (k)
        0: exp_d = 16'h1000;
        1: exp_d = 16'h2000;
        2: exp_d = 16'h1001;
        3: exp_d = 16'h2001;
        default: exp_d = 16'h0000;
      endcase
      expect_eq("rr_wdata", {16'd0, rf_wdata}, {16'd0, exp_d});
      if (k % 2 == 0) req0_data = req0_data + 16'd1;
      else            req1_data = req1_data + 16'd1;
    end
    expect_eq("rr_cnt", {24'd0, conflict_cnt}, 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Same address from reset: port 0 then port 1, r3 ends at 0x5555
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 16'h5555;
    #1;
    expect_eq("same_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    expect_eq("same_first", {16'd0, rf_wdata}, 32'hAAAA);
    req0_valid = 1'b0;
    #1;
    expect_eq("same_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    expect_eq("same_second", {16'd0, rf_wdata}, 32'h5555);
    expect_eq("same_addr", {27'd0, rf_addr}, 32'd3);
    req1_valid = 1'b0;
    tick();
    expect_eq("same_r3", {16'd0, model_rf[3]}, 32'h5555);
    expect_eq("same_cnt", {24'd0, conflict_cnt}, 32'd1);

    // Saturation of the contention counter
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 16'h0404;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 16'h0606;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254) expect_eq("sat_254", {24'd0, conflict_cnt}, 32'd254);
      if (k == 255) expect_eq("sat_255", {24'd0, conflict_cnt}, 32'd255);
      if (k == 300) expect_eq("sat_300", {24'd0, conflict_cnt}, 32'd255);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Zero-register write from port 1
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 16'hFFFF;
    #1;
    expect_eq("r0_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
`ifdef RFWB_R0_DISCARD_EN
    expect_eq("r0_we_discard", {31'd0, rf_we}, 32'd0);
`else
    expect_eq("r0_we", {31'd0, rf_we}, 32'd1);
    expect_eq("r0_addr", {27'd0, rf_addr}, 32'd0);
    expect_eq("r0_data", {16'd0, rf_wdata}, 32'hFFFF);
`endif
    tick();
    expect_eq("r0_we_after", {31'd0, rf_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 16-bit CPU register file. It shares the register file's single write port between two requesters, port 0 (ALU result) and port 1 (load data from memory), using valid/ready handshakes and round-robin arbitration. The granted write is registered and presented to the register file's write enable, address and data inputs one cycle after acceptance. A saturating counter records cycles in which both requesters contend.

## Interface
- WIDTH, 16, data width of a register-file write
- DEPTH, 32, number of registers in the register file
- ADDR_SIZE, $clog2(DEPTH), register address width
- CNT_WIDTH, 8, width of the contention counter

- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req0_valid  input  1  port 0 (ALU) has a write pending
- req0_addr  input  ADDR_SIZE  port 0 destination register
- req0_data  input  WIDTH  port 0 write data
- req0_ready  output  1  port 0 write accepted this cycle
- req1_valid  input  1  port 1 (load) has a write pending
- req1_addr  input  ADDR_SIZE  port 1 destination register
- req1_data  input  WIDTH  port 1 write data
- req1_ready  output  1  port 1 write accepted this cycle
- rf_we  output  1  register-file write enable, registered
- rf_addr  output  ADDR_SIZE  register-file write address, registered
- rf_wdata  output  WIDTH  register-file write data, registered
- conflict_cnt  output  CNT_WIDTH  saturating count of cycles with both valid

## Operation
- Handshake: a transfer on port i occurs at a rising edge where reqi_valid && reqi_ready.
- While valid is high, the requester holds addr and data stable until the transfer. Valid must not drop before ready.
- reqi_ready is combinational from the valids and the `last` pointer, and is high only when reqi_valid is high.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port other than `last` is granted.
  - Neither valid: no grant.
  - At most one ready is high in any cycle.
- `last` pointer (1 bit): on every transfer it is set to the granted port index. Reset value is 1, so port 0 wins the first tie.
- Output register on a transfer: rf_we<=1, rf_addr<=granted addr, rf_wdata<=granted data.
- Without a transfer: rf_we<=0, and rf_addr/rf_wdata hold their values.
- Same-address contention: no merging. Each write is granted in turn, and the later grant overwrites the earlier one in the register file.
- conflict_cnt: increments on every edge where req0_valid && req1_valid. It saturates at 2^CNT_WIDTH-1 and does not wrap.
- Arbitration logic is combinational; the output register and the counter are the only state besides `last`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - rf_we=0, rf_addr=0, rf_wdata=0, conflict_cnt=0, last=1.
  - req0_ready and req1_ready are 0 while rst is high, regardless of the valids.
- Latency: a transfer at edge N drives rf_we high during cycle N..N+1, so the register file captures the write at edge N+1.
- Throughput: one write per cycle. Under continuous dual contention, the grants alternate 0,1,0,1,...
- Maximum wait for a valid requester is one cycle (no starvation).
- Reset mid-operation: a registered write not yet captured is dropped (rf_we forced to 0). Requesters must re-present after reset.

## Configuration
- RFWB_R0_DISCARD_EN defined: a transfer whose address is 0 still completes the handshake and still updates `last`, but loads rf_we<=0. This keeps r0 hardwired to zero.
- RFWB_R0_DISCARD_EN undefined: address 0 is written like any other register.
- conflict_cnt behaviour is identical in both builds.

## Test plan
- Reset check: assert rst mid-cycle with req0_valid=1 → rf_we, rf_addr, rf_wdata and conflict_cnt read 0 immediately, and both readys are 0.
- Single writer: req0 presents addr=5, data=0x1234 for one cycle → req0_ready=1 that cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=0x1234; following cycle rf_we=0.
- Round-robin: both valid continuously for 4 cycles with distinct data → grants 0,1,0,1; rf_wdata sequence matches; conflict_cnt=4.
- Same address: req0 (addr=3, 0xAAAA) and req1 (addr=3, 0x5555) both valid from reset → port 0 is written first, then port 1; r3 ends at 0x5555.
- Saturation: hold both valid for 300 cycles with CNT_WIDTH=8 → conflict_cnt stops at 255 and does not wrap.
- Zero-register write, req1 addr=0, data=0xFFFF:
  - With RFWB_R0_DISCARD_EN: req1_ready=1 and rf_we stays 0.
  - Without it: rf_we=1 and rf_addr=0 the next cycle.
